// File: rtl/cti8_bus_pkg.sv
// Shared types and constants for the CTI-8 memory-side responder.
package cti8_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    ACK  = 2'b10
  } rsp_state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } bus_op_t;

  localparam logic [15:0] VEC_BASE = 16'hFFFC;

  function automatic logic is_vec(input logic [15:0] addr);
    return addr[15:2] == VEC_BASE[15:2];
  endfunction

endpackage

// File: rtl/mem_bus_responder_if.sv
// CTI-8 address/request/ready bundle; the shared data bus stays a separate inout net.
interface mem_bus_responder_if;

  logic [15:0] address;
  logic        rd;
  logic        wr;
  logic        ready;

  modport master (output address, output rd, output wr, input ready);
  modport slave  (input address, input rd, input wr, output ready);

endinterface

// File: rtl/responder_ram.sv
// Single-port synchronous byte RAM, one-cycle read, contents not reset.
module responder_ram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    din,
  output logic [7:0]    dout
);

  logic [7:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= din;
      end
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side CTI-8 responder: decodes RAM window and vector table, serves byte
// accesses after WAIT_STATES enabled cycles, and acknowledges with a one-cycle ready.
module mem_bus_responder
  import cti8_bus_pkg::*;
#(
  parameter int          RAM_AW      = 10,
  parameter logic [15:0] RAM_BASE    = 16'h0000,
  parameter int          WAIT_STATES = 1,
  parameter logic [15:0] RESET_VEC   = 16'h8000,
  parameter logic [15:0] IRQ_VEC     = 16'h8000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_en,
  mem_bus_responder_if.slave bus,
  inout  wire  [7:0]         data
);

  localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);

  rsp_state_t        state;
  rsp_state_t        state_nxt;
  bus_op_t           op_q;
  logic [15:0]       addr_q;
  logic [7:0]        wdat_q;
  logic [3:0]        cnt_q;
  logic              sel;
  logic              req_ok;
  logic              req_held;
  logic              drive;
  logic [7:0]        vec_byte;
  logic [7:0]        rd_byte;
  logic [7:0]        ram_dout;
  logic [RAM_AW-1:0] ram_addr;
  logic              ram_we;

  assign sel = (bus.address[15:RAM_AW] == RAM_BASE[15:RAM_AW]) | is_vec(bus.address);
  // Simultaneous rd and wr is a protocol error and is never accepted.
  assign req_ok   = sel & (bus.rd ^ bus.wr);
  assign req_held = (op_q == OP_WR) ? bus.wr : bus.rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (clk_en) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req_ok) begin
          state_nxt = (WAIT_STATES == 0) ? ACK : WAIT;
        end
      end
      WAIT: begin
        if (!req_held) begin
          state_nxt = IDLE;
        end else if (cnt_q == 4'd1) begin
          state_nxt = ACK;
        end
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.ready = 1'b0;
    drive     = 1'b0;
    if (state == ACK) begin
      bus.ready = 1'b1;
      drive     = (op_q == OP_RD);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      wdat_q <= '0;
      op_q   <= OP_RD;
      cnt_q  <= '0;
    end else if (clk_en) begin
      if (state == IDLE && req_ok) begin
        addr_q <= bus.address;
        op_q   <= bus.wr ? OP_WR : OP_RD;
        cnt_q  <= WS_CNT;
        if (bus.wr) begin
          wdat_q <= data;
        end
      end else if (state == WAIT && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  always_comb begin
    vec_byte = 8'h00;
    case (addr_q[1:0])
      2'd0: vec_byte = RESET_VEC[7:0];
      2'd1: vec_byte = RESET_VEC[15:8];
      2'd2: vec_byte = IRQ_VEC[7:0];
      2'd3: vec_byte = IRQ_VEC[15:8];
      default: vec_byte = 8'h00;
    endcase
  end

  // Read is launched from the live address on the capture edge and re-issued from
  // the latched address afterwards, so dout is stable by the time ACK is reached.
  assign ram_addr = (state == IDLE) ? bus.address[RAM_AW-1:0] : addr_q[RAM_AW-1:0];
  assign ram_we   = (state == ACK) && (op_q == OP_WR) && !is_vec(addr_q);

  responder_ram #(
    .AW (RAM_AW)
  ) u_ram (
    .clk  (clk),
    .en   (clk_en),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (wdat_q),
    .dout (ram_dout)
  );

  assign rd_byte = is_vec(addr_q) ? vec_byte : ram_dout;
  assign data    = drive ? rd_byte : 8'hzz;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: two instances (1 and 3 wait states) share the request lines.
module tb_mem_bus_responder;

  logic        clk     = 1'b0;
  logic        rst     = 1'b1;
  logic        clk_en  = 1'b1;
  logic [15:0] address = 16'h0000;
  logic        rd      = 1'b0;
  logic        wr      = 1'b0;
  logic        drv_en  = 1'b0;
  logic [7:0]  drv_dat = 8'h00;
  wire  [7:0]  data1;
  wire  [7:0]  data3;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          lat;
  int          cnt;
  logic [7:0]  rb;

  mem_bus_responder_if bus1 ();
  mem_bus_responder_if bus3 ();

  assign bus1.address = address;
  assign bus1.rd      = rd;
  assign bus1.wr      = wr;
  assign bus3.address = address;
  assign bus3.rd      = rd;
  assign bus3.wr      = wr;

  // An undriven bus floats high, so a released bus reads back 8'hFF.
  pullup pu_d1 (data1);
  pullup pu_d3 (data3);
  assign data1 = drv_en ? drv_dat : 8'hzz;
  assign data3 = drv_en ? drv_dat : 8'hzz;

  always #5 clk = ~clk;

  mem_bus_responder #(
    .RAM_AW(10), .RAM_BASE(16'h0000), .WAIT_STATES(1), .RESET_VEC(16'h8000), .IRQ_VEC(16'h1234)
  ) u_ws1 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .bus(bus1.slave), .data(data1)
  );

  mem_bus_responder #(
    .RAM_AW(10), .RAM_BASE(16'h0000), .WAIT_STATES(3), .RESET_VEC(16'h8000), .IRQ_VEC(16'h8000)
  ) u_ws3 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .bus(bus3.slave), .data(data3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds a request until the chosen instance raises ready (bounded), then releases the bus.
  task automatic access(input logic is_wr, input logic [15:0] a, input logic [7:0] d,
                        input logic on3, output int l, output logic [7:0] r);
    address = a;
    wr      = is_wr;
    rd      = ~is_wr;
    drv_en  = is_wr;
    drv_dat = d;
    l       = 0;
    r       = 8'h00;
    while (l < 40) begin
      tick();
      l++;
      if ((on3 ? bus3.ready : bus1.ready) === 1'b1) break;
    end
    r      = on3 ? data3 : data1;
    rd     = 1'b0;
    wr     = 1'b0;
    drv_en = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (bus1.ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready1: got %b want 0", bus1.ready); end
    n_cmp++; if (bus3.ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready3: got %b want 0", bus3.ready); end
    n_cmp++; if (data1 !== 8'hFF) begin n_bad++; $display("FAIL rst_data1: got %h want ff (released)", data1); end
    n_cmp++; if (data3 !== 8'hFF) begin n_bad++; $display("FAIL rst_data3: got %h want ff (released)", data3); end
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (bus1.ready !== 1'b0) begin n_bad++; $display("FAIL post_rst_ready1: got %b want 0", bus1.ready); end
  endtask

  task automatic test_write_read();
    access(1'b1, 16'h0010, 8'h5A, 1'b0, lat, rb);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL wr_latency: got %0d want 2", lat); end
    n_cmp++; if (bus1.ready !== 1'b0) begin n_bad++; $display("FAIL wr_ready_width: got %b want 0", bus1.ready); end
    access(1'b0, 16'h0010, 8'h00, 1'b0, lat, rb);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL rd_latency: got %0d want 2", lat); end
    n_cmp++; if (rb !== 8'h5A) begin n_bad++; $display("FAIL rd_data_0010: got %h want 5a", rb); end
    n_cmp++; if (data1 !== 8'hFF) begin n_bad++; $display("FAIL rd_release: got %h want ff", data1); end
  endtask

  task automatic test_vectors();
    access(1'b1, 16'h03FC, 8'h66, 1'b0, lat, rb);
    access(1'b0, 16'hFFFC, 8'h00, 1'b0, lat, rb);
    n_cmp++; if (rb !== 8'h00) begin n_bad++; $display("FAIL vec_fffc: got %h want 00", rb); end
    access(1'b0, 16'hFFFD, 8'h00, 1'b0, lat, rb);
    n_cmp++; if (rb !== 8'h80) begin n_bad++; $display("FAIL vec_fffd: got %h want 80", rb); end
    access(1'b0, 16'hFFFE, 8'h00, 1'b0, lat, rb);
    n_cmp++; if (rb !== 8'h34) begin n_bad++; $display("FAIL vec_fffe: got %h want 34", rb); end
    access(1'b0, 16'hFFFF, 8'h00, 1'b0, lat, rb);
    n_cmp++; if (rb !== 8'h12) begin n_bad++; $display("FAIL vec_ffff: got %h want 12", rb); end
    access(1'b1, 16'hFFFC, 8'h12, 1'b0, lat, rb);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL vec_wr_ack: got latency %0d want 2", lat); end
    access(1'b0, 16'hFFFC, 8'h00, 1'b0, lat, rb);
    n_cmp++; if (rb !== 8'h00) begin n_bad++; $display("FAIL vec_wr_discard: got %h want 00", rb); end
    access(1'b0, 16'h03FC, 8'h00, 1'b0, lat, rb);
    n_cmp++; if (rb !== 8'h66) begin n_bad++; $display("FAIL vec_wr_ram_alias: got %h want 66", rb); end
  endtask

  task automatic test_abort();
    access(1'b1, 16'h0020, 8'h33, 1'b1, lat, rb);
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL ws3_wr_latency: got %0d want 4", lat); end
    address = 16'h0020;
    wr      = 1'b1;
    drv_en  = 1'b1;
    drv_dat = 8'h77;
    tick();
    wr     = 1'b0;
    drv_en = 1'b0;
    cnt    = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus3.ready !== 1'b0 || bus1.ready !== 1'b0) cnt++;
    end
    n_cmp++; if (cnt !== 0) begin n_bad++; $display("FAIL abort_ready: got %0d ready cycles want 0", cnt); end
    access(1'b0, 16'h0020, 8'h00, 1'b1, lat, rb);
    n_cmp++; if (rb !== 8'h33) begin n_bad++; $display("FAIL abort_ws3_data: got %h want 33", rb); end
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL ws3_rd_latency: got %0d want 4", lat); end
    access(1'b0, 16'h0020, 8'h00, 1'b0, lat, rb);
    n_cmp++; if (rb !== 8'h33) begin n_bad++; $display("FAIL abort_ws1_data: got %h want 33", rb); end
  endtask

  task automatic test_unmapped();
    address = 16'h4000;
    rd      = 1'b1;
    cnt     = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus1.ready !== 1'b0 || bus3.ready !== 1'b0 || data1 !== 8'hFF || data3 !== 8'hFF) cnt++;
    end
    rd = 1'b0;
    n_cmp++; if (cnt !== 0) begin n_bad++; $display("FAIL unmapped: got %0d active cycles want 0", cnt); end
    access(1'b1, 16'h0001, 8'h4C, 1'b0, lat, rb);
    address = 16'h0001;
    rd      = 1'b1;
    wr      = 1'b1;
    drv_en  = 1'b1;
    drv_dat = 8'h99;
    cnt     = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus1.ready !== 1'b0 || bus3.ready !== 1'b0) cnt++;
    end
    rd     = 1'b0;
    wr     = 1'b0;
    drv_en = 1'b0;
    tick();
    n_cmp++; if (cnt !== 0) begin n_bad++; $display("FAIL rdwr_ready: got %0d ready cycles want 0", cnt); end
    access(1'b0, 16'h0001, 8'h00, 1'b0, lat, rb);
    n_cmp++; if (rb !== 8'h4C) begin n_bad++; $display("FAIL rdwr_ram: got %h want 4c", rb); end
  endtask

  task automatic test_clk_en();
    address = 16'h0020;
    rd      = 1'b1;
    lat     = 0;
    cnt     = 0;
    tick(); lat++;
    tick(); lat++;
    clk_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(); lat++;
      if (bus3.ready !== 1'b0) cnt++;
    end
    clk_en = 1'b1;
    while (lat < 40) begin
      tick(); lat++;
      if (bus3.ready === 1'b1) break;
      if (bus3.ready !== 1'b0) cnt++;
    end
    n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL gated_latency: got %0d want 9", lat); end
    n_cmp++; if (cnt !== 0) begin n_bad++; $display("FAIL gated_spurious: got %0d want 0", cnt); end
    n_cmp++; if (data3 !== 8'h33) begin n_bad++; $display("FAIL gated_data: got %h want 33", data3); end
    clk_en = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    n_cmp++; if (bus3.ready !== 1'b1) begin n_bad++; $display("FAIL frozen_ready: got %b want 1", bus3.ready); end
    n_cmp++; if (data3 !== 8'h33) begin n_bad++; $display("FAIL frozen_data: got %h want 33", data3); end
    clk_en = 1'b1;
    rd     = 1'b0;
    tick();
    n_cmp++; if (bus3.ready !== 1'b0) begin n_bad++; $display("FAIL gated_ready_width: got %b want 0", bus3.ready); end
    tick();
  endtask

  task automatic test_reset_mid();
    address = 16'h0010;
    rd      = 1'b1;
    tick();
    tick();
    n_cmp++; if (bus1.ready !== 1'b1 || data1 !== 8'h5A) begin
      n_bad++; $display("FAIL pre_rst_ack: got ready %b data %h want 1/5a", bus1.ready, data1);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus1.ready !== 1'b0) begin n_bad++; $display("FAIL async_rst_ready1: got %b want 0", bus1.ready); end
    n_cmp++; if (data1 !== 8'hFF) begin n_bad++; $display("FAIL async_rst_data1: got %h want ff", data1); end
    n_cmp++; if (bus3.ready !== 1'b0 || data3 !== 8'hFF) begin
      n_bad++; $display("FAIL async_rst_ws3: got ready %b data %h want 0/ff", bus3.ready, data3);
    end
    rd = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    access(1'b1, 16'h0000, 8'hC3, 1'b0, lat, rb);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL post_rst_wr_latency: got %0d want 2", lat); end
    access(1'b0, 16'h0000, 8'h00, 1'b0, lat, rb);
    n_cmp++; if (lat !== 2 || rb !== 8'hC3) begin
      n_bad++; $display("FAIL post_rst_rd: got latency %0d data %h want 2/c3", lat, rb);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_vectors();
    test_abort();
    test_unmapped();
    test_clk_en();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
